// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: operand/result handshake bundle for the nibble-serial adder.
interface nibble_serial_add_ctrl_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two WIDTH-bit operands one nibble per cycle through a single 4-bit slice.
// Define SUB_EN to let op_sub select a-b (b inverted, initial carry forced to 1).
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input logic clk,
    input logic rst_n,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N);
`ifdef SUB_EN
    localparam bit SUB_EN_ON = 1'b1;
`else
    localparam bit SUB_EN_ON = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, next;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic [CW-1:0]    cnt;
    logic             carry, cout_r, sub, accept, last;
    logic [4:0]       slice;
    assign sub    = SUB_EN_ON && bus.op_sub;
    assign accept = bus.in_valid && state == IDLE;
    assign last   = cnt == CW'(N - 1);
    assign slice  = {1'b0, a_r[{cnt, 2'b00} +: 4]} + {1'b0, b_r[{cnt, 2'b00} +: 4]} + {4'b0, carry};
    always_comb
        next = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
                               (bus.out_ready ? IDLE : DONE);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                a_r   <= bus.a;
                b_r   <= sub ? ~bus.b : bus.b;
                carry <= sub | bus.cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                sum_r[{cnt, 2'b00} +: 4] <= slice[3:0];
                carry <= slice[4];
                cnt   <= cnt + 1'b1;
                if (last) cout_r <= slice[4];
            end
        end
    end
    // b_r already holds the inverted operand for subtraction, so this is the b_eff overflow rule
    assign bus.ovf       = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ sum_r[WIDTH-1] ^ cout_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.in_ready  = state == IDLE;
    assign bus.busy      = state == RUN;
    assign bus.out_valid = state == DONE;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed and randomized checks of the nibble-serial adder against an arithmetic model.
module tb_nibble_serial_add_ctrl;
    localparam int W = 16;
    localparam int N = W / 4;
`ifdef SUB_EN
    localparam bit sub_en = 1'b1;
`else
    localparam bit sub_en = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    nibble_serial_add_ctrl_if #(.WIDTH(W)) bus();
    nibble_serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int total = 0;
    int bad = 0;
    // model: 0 waiting for operands, 1 computing, 2 result presented
    int phase = 0;
    int k = 0;
    logic [W-1:0] e_sum, be;
    logic [W:0]   r;
    logic         e_cout, e_ovf, msub;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase = 0;
        else if (phase == 0) begin
            if (bus.in_valid) begin
                msub   = sub_en && bus.op_sub;
                be     = msub ? ~bus.b : bus.b;
                r      = {1'b0, bus.a} + {1'b0, be} + {{W{1'b0}}, msub | bus.cin};
                e_sum  = r[W-1:0];
                e_cout = r[W];
                e_ovf  = bus.a[W-1] ^ be[W-1] ^ e_sum[W-1] ^ e_cout;
                phase  = 1;
                k      = 0;
            end
        end else if (phase == 1) begin
            k++;
            if (k == N) phase = 2;
        end else if (bus.out_ready) phase = 0;
    end
    always @(negedge clk) begin
        chk("in_ready", 32'(bus.in_ready), 32'(phase == 0));
        chk("busy", 32'(bus.busy), 32'(phase == 1));
        chk("out_valid", 32'(bus.out_valid), 32'(phase == 2));
        if (!rst_n) begin
            chk("rst_sum", 32'(bus.sum), 32'(0));
            chk("rst_cout", 32'(bus.cout), 32'(0));
            chk("rst_ovf", 32'(bus.ovf), 32'(0));
        end
        if (phase == 2) begin
            chk("sum", 32'(bus.sum), 32'(e_sum));
            chk("cout", 32'(bus.cout), 32'(e_cout));
            chk("ovf", 32'(bus.ovf), 32'(e_ovf));
        end
    end
    task automatic wait_result(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask
    task automatic op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic s, input logic [W-1:0] xs, input logic xc, input logic xo);
        int n, bz;
        bus.a = a; bus.b = b; bus.cin = c; bus.op_sub = s; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bz = int'(bus.busy);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
            bz += int'(bus.busy);
        end
        chk({nm, "_latency"}, 32'(n), 32'(N));
        chk({nm, "_busy_cycles"}, 32'(bz), 32'(N));
        chk({nm, "_sum"}, 32'(bus.sum), 32'(xs));
        chk({nm, "_cout"}, 32'(bus.cout), 32'(xc));
        chk({nm, "_ovf"}, 32'(bus.ovf), 32'(xo));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask
    function automatic logic [W-1:0] pick();
        int s;
        s = $urandom_range(0, 5);
        return s == 0 ? 16'h0000 : s == 1 ? 16'hFFFF : s == 2 ? 16'h7FFF : s == 3 ? 16'h8000 : 16'($urandom);
    endfunction
    initial begin
        int n;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op_sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'(1));
        chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
        chk("reset_sum", 32'(bus.sum), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        op("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        op("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, sub_en ? 16'hFFFE : 16'h000C, 1'b0, 1'b0);
        bus.a = 16'hAAAA; bus.b = 16'h1111; bus.cin = 1'b0; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            bus.a = 16'($urandom); bus.b = 16'($urandom);
            @(negedge clk);
            n++;
        end
        chk("hold_latency", 32'(n), 32'(N));
        repeat (10) begin
            bus.a = 16'($urandom); bus.b = 16'($urandom);
            @(negedge clk);
            chk("hold_sum", 32'(bus.sum), 32'(16'hBBBB));
            chk("hold_in_ready", 32'(bus.in_ready), 32'(0));
            chk("hold_out_valid", 32'(bus.out_valid), 32'(1));
        end
        bus.a = 16'h0102; bus.b = 16'h0304; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(bus.in_ready), 32'(1));
        chk("release_out_valid", 32'(bus.out_valid), 32'(0));
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("reaccept_busy", 32'(bus.busy), 32'(1));
        bus.in_valid = 1'b0;
        wait_result(n);
        chk("reaccept_sum", 32'(bus.sum), 32'(16'h0406));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.a = 16'hABCD; bus.b = 16'h0001; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'(0));
        chk("async_in_ready", 32'(bus.in_ready), 32'(1));
        chk("async_busy", 32'(bus.busy), 32'(0));
        chk("async_sum", 32'(bus.sum), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("no_result_after_rst", 32'(bus.out_valid), 32'(0));
        end
        op("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        repeat (600) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.a         = pick();
            bus.b         = pick();
            bus.cin       = 1'($urandom_range(0, 1));
            bus.op_sub    = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits; it must be a multiple of 4 and at least 8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, operands and cin are valid.
REQ-005 The block SHALL have port in_ready, output, 1, the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, operands.
REQ-007 The block SHALL have port cin, input, 1, carry-in to nibble 0.
REQ-008 The block SHALL have port op_sub, input, 1, subtract request; it is significant only per REQ-026/REQ-027.
REQ-009 The block SHALL have port out_valid, output, 1, result is valid.
REQ-010 The block SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH, the result.
REQ-012 The block SHALL have port cout, output, 1, carry out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1, two's-complement overflow.
REQ-014 The block SHALL have port busy, output, 1, an operation is in progress (RUN state).

Function
REQ-015 The block SHALL add a and b over N=WIDTH/4 cycles, one nibble per cycle, through one internal 4-bit ripple-carry adder slice, least-significant nibble first.
REQ-016 The FSM SHALL have exactly three states:
- IDLE: in_ready=1.
- RUN: busy=1.
- DONE: out_valid=1.
REQ-017 The acceptance handshake SHALL be in_valid&in_ready; on acceptance the block captures a, b, cin and op_sub, clears the nibble counter and moves IDLE->RUN.
REQ-018 In RUN, each cycle SHALL add nibble k of a and b plus the carry register, write sum nibble k, latch the slice carry-out into the carry register, and increment k.
REQ-019 After nibble N-1 the FSM SHALL move RUN->DONE, so that out_valid rises exactly N rising edges after the acceptance edge (4 for WIDTH=16).
REQ-020 cout SHALL be the carry-out of nibble N-1.
REQ-021 ovf SHALL be a[MSB] ^ b_eff[MSB] ^ sum[MSB] ^ cout, where b_eff is b after any inversion per REQ-026.
REQ-022 In DONE, sum, cout and ovf SHALL be held stable until out_valid&out_ready; on that edge the FSM moves DONE->IDLE.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, with no queuing and no overlap of operations.
REQ-024 out_ready SHALL have no effect outside DONE; when out_ready is already high on entry to DONE, DONE lasts exactly one cycle.
REQ-025 The carry chain SHALL wrap from nibble N-1 only into cout; it is never fed back into nibble 0.

Configuration
REQ-026 With the macro SUB_EN defined, op_sub=1 captured at acceptance SHALL select a-b: b is inverted bitwise, the initial carry is 1, cin is ignored, and cout=1 means no borrow.
REQ-027 Without SUB_EN, op_sub SHALL be ignored and the operation is always a+b+cin; the port remains present.

Reset
REQ-028 While rst_n=0, the outputs SHALL be forced immediately, independent of clk, to: FSM=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, and the counter and carry register cleared.
REQ-029 Reset asserted during RUN or DONE SHALL discard the operation, and no out_valid SHALL follow.
REQ-030 After rst_n deasserts, the first rising edge with in_valid=1 SHALL accept normally.

Verification
REQ-031 The bench SHALL cover these directed scenarios (WIDTH=16):
- a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 edges after accept; busy high for 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry propagates through all nibbles).
- a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Result with out_ready held 0 for 10 cycles and in_valid=1 throughout -> sum/cout/ovf stable, in_ready=0, no second accept; release out_ready -> IDLE next edge, then accept.
- rst_n pulsed low during the 2nd RUN cycle -> out_valid=0 and in_ready=1 asynchronously, no result emitted; the next operation 0x0001+0x0002 gives 0x0003.
- a=0x0005, b=0x0007, op_sub=1, cin=0: with SUB_EN -> sum=0xFFFE, cout=0, ovf=0; without SUB_EN -> sum=0x000C, cout=0.
